// File: rtl/vga_disp_pkg.sv
// Shared display constants for the VGA number renderers and their frame-coherent loader.
package vga_disp_pkg;

  localparam int unsigned NUM_FIELDS  = 9;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned SHADOW_W    = NUM_FIELDS * BYTE_W;
  localparam int unsigned STAGE_W     = (NUM_FIELDS - 1) * BYTE_W;
  localparam int unsigned FIELD_IDX_W = 4;
  localparam int unsigned ADDR_W      = 8;

  // Field indices into the shadow byte array
  localparam int unsigned HOUR0  = 0;
  localparam int unsigned HOUR1  = 1;
  localparam int unsigned HOUR2  = 2;
  localparam int unsigned DATE0  = 3;
  localparam int unsigned DATE1  = 4;
  localparam int unsigned DATE2  = 5;
  localparam int unsigned TIMER0 = 6;
  localparam int unsigned TIMER1 = 7;
  localparam int unsigned TIMER2 = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_READ   = 2'd2,
    ST_COMMIT = 2'd3
  } ld_state_e;

  // One-hot field mask; indices beyond the last field give an empty mask
  function automatic logic [NUM_FIELDS-1:0] field_onehot(input logic [FIELD_IDX_W-1:0] idx);
    logic [NUM_FIELDS-1:0] oh;
    oh = '0;
    if (idx < FIELD_IDX_W'(NUM_FIELDS)) oh = NUM_FIELDS'(1) << idx;
    return oh;
  endfunction

endpackage

// File: rtl/vga_blink_gen.sv
// Blink phase generator for the field under edit: counts frames and toggles the
// phase every BLINK_FRAMES frames. Only built when VGA_FIELD_BLINK_EN is defined.
`ifdef VGA_FIELD_BLINK_EN
module vga_blink_gen #(
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_i,
  output logic phase_o
);

  localparam int unsigned CNT_W = 5;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Next frame count and phase; phase 1 means the field is blanked
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_i) begin
      if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and phase registers, visible phase out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule
`endif

// File: rtl/vga_frame_sync_loader.sv
// Frame-coherent loader of the nine display bytes. On each vertical-retrace start
// with new RTC contents pending, it borrows the shared register-file read port,
// reads nine bytes and commits them to the shadow registers in a single cycle.
// Optional field blinking for edit mode is enabled with VGA_FIELD_BLINK_EN.
module vga_frame_sync_loader
  import vga_disp_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR    = 8'h00,
  parameter int unsigned GNT_TIMEOUT  = 64,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic                   dirty_i,
  output logic                   bus_req_o,
  input  logic                   bus_gnt_i,
  output logic                   rd_en_o,
  output logic [ADDR_W-1:0]      rd_addr_o,
  input  logic [BYTE_W-1:0]      rd_data_i,
  output logic [SHADOW_W-1:0]    shadow_o,
  output logic                   loaded_o,
  output logic [7:0]             miss_cnt_o,
  input  logic                   edit_en_i,
  input  logic [FIELD_IDX_W-1:0] edit_field_i,
  output logic [NUM_FIELDS-1:0]  field_blank_o
);

  localparam int unsigned TMO_W = 16;
  localparam int unsigned IDX_W = 4;

  ld_state_e            state_q, state_d;
  logic                 vsync_q;
  logic                 retrace_q;
  logic                 pending_q, pending_d;
  logic                 bus_req_q, bus_req_d;
  logic                 rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [IDX_W-1:0]     cap_idx_q, cap_idx_d;
  logic [STAGE_W-1:0]   staging_q, staging_d;
  logic [SHADOW_W-1:0]  shadow_q, shadow_d;
  logic                 loaded_q, loaded_d;
  logic [7:0]           miss_q, miss_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 commit_c;

  // Registered vsync falling-edge detect marks retrace start
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q   <= 1'b1;
      retrace_q <= 1'b0;
    end else begin
      vsync_q   <= vsync;
      retrace_q <= vsync_q & ~vsync;
    end
  end

  // Next-state and output logic; the ninth byte goes straight into the shadow commit
  always_comb begin
    state_d   = state_q;
    bus_req_d = bus_req_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    rd_idx_d  = rd_idx_q;
    rd_vld_d  = 1'b0;
    cap_idx_d = cap_idx_q;
    staging_d = staging_q;
    shadow_d  = shadow_q;
    loaded_d  = 1'b0;
    miss_d    = miss_q;
    tmo_d     = tmo_q;
    commit_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (retrace_q && pending_q) begin
          state_d   = ST_REQ;
          bus_req_d = 1'b1;
          tmo_d     = '0;
        end
      end

      ST_REQ: begin
        if (bus_gnt_i) begin
          state_d   = ST_READ;
          rd_en_d   = 1'b1;
          rd_addr_d = BASE_ADDR;
          rd_idx_d  = IDX_W'(1);
          cap_idx_d = '0;
          staging_d = '0;
        end else if (tmo_q == TMO_W'(GNT_TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      ST_READ: begin
        if (!bus_gnt_i) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          rd_en_d   = 1'b0;
          rd_idx_d  = '0;
          cap_idx_d = '0;
          staging_d = '0;
        end else begin
          rd_vld_d = rd_en_q;
          if (rd_idx_q < IDX_W'(NUM_FIELDS)) begin
            rd_en_d   = 1'b1;
            rd_addr_d = BASE_ADDR + ADDR_W'(rd_idx_q);
            rd_idx_d  = rd_idx_q + IDX_W'(1);
          end else begin
            rd_en_d = 1'b0;
          end
          if (rd_vld_q) begin
            if (cap_idx_q == IDX_W'(NUM_FIELDS - 1)) begin
              state_d   = ST_COMMIT;
              shadow_d  = {rd_data_i, staging_q};
              loaded_d  = 1'b1;
              bus_req_d = 1'b0;
              staging_d = '0;
              commit_c  = 1'b1;
            end else begin
              staging_d[{cap_idx_q[2:0], 3'b000} +: BYTE_W] = rd_data_i;
              cap_idx_d = cap_idx_q + IDX_W'(1);
            end
          end
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
        rd_en_d   = 1'b0;
      end
    endcase

    pending_d = (pending_q & ~commit_c) | dirty_i;
  end

  // State and output registers; first frame after reset always loads
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b1;
      bus_req_q <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_idx_q  <= '0;
      rd_vld_q  <= 1'b0;
      cap_idx_q <= '0;
      staging_q <= '0;
      shadow_q  <= '0;
      loaded_q  <= 1'b0;
      miss_q    <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      bus_req_q <= bus_req_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_idx_q  <= rd_idx_d;
      rd_vld_q  <= rd_vld_d;
      cap_idx_q <= cap_idx_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      loaded_q  <= loaded_d;
      miss_q    <= miss_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus_req_o  = bus_req_q;
  assign rd_en_o    = rd_en_q;
  assign rd_addr_o  = rd_addr_q;
  assign shadow_o   = shadow_q;
  assign loaded_o   = loaded_q;
  assign miss_cnt_o = miss_q;

`ifdef VGA_FIELD_BLINK_EN
  logic                  blink_off;
  logic [NUM_FIELDS-1:0] field_blank_q, field_blank_d;

  vga_blink_gen #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk    (clk),
    .reset  (reset),
    .frame_i(retrace_q),
    .phase_o(blink_off)
  );

  // Blank the edited field during the off phase
  always_comb begin
    field_blank_d = '0;
    if (edit_en_i && blink_off) field_blank_d = field_onehot(edit_field_i);
  end

  // Registered blank mask
  always_ff @(posedge clk) begin
    if (reset) field_blank_q <= '0;
    else       field_blank_q <= field_blank_d;
  end

  assign field_blank_o = field_blank_q;
`else
  logic unused_c;
  assign unused_c      = ^{edit_en_i, edit_field_i, 5'(BLINK_FRAMES)};
  assign field_blank_o = '0;
`endif

endmodule

// File: tb/tb_vga_frame_sync_loader.sv
// Directed bench for vga_frame_sync_loader with a one-cycle-latency register-file responder.
`timescale 1ns/1ps
module tb_vga_frame_sync_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        dirty_i;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [7:0]  rd_data_i;
  logic [71:0] shadow_o;
  logic        loaded_o;
  logic [7:0]  miss_cnt_o;
  logic        edit_en_i;
  logic [3:0]  edit_field_i;
  logic [8:0]  field_blank_o;

  logic gnt_auto;
  logic gnt_man;
  logic gnt_kill;
  logic [7:0] rf [256];

  int total  = 0;
  int passed = 0;

  int cyc      = 0;
  int load_cnt = 0;
  int load_cyc = 0;
  int gnt_cyc  = 0;
  int req_cnt  = 0;
  int rd_cnt   = 0;
  int chg_cnt  = 0;
  int bad_chg  = 0;
  logic        gnt_prev    = 1'b0;
  logic [71:0] shadow_prev = '0;

  always #5 clk = ~clk;

  assign bus_gnt_i = gnt_auto ? (bus_req_o & ~gnt_kill) : gnt_man;

  vga_frame_sync_loader dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .dirty_i      (dirty_i),
    .bus_req_o    (bus_req_o),
    .bus_gnt_i    (bus_gnt_i),
    .rd_en_o      (rd_en_o),
    .rd_addr_o    (rd_addr_o),
    .rd_data_i    (rd_data_i),
    .shadow_o     (shadow_o),
    .loaded_o     (loaded_o),
    .miss_cnt_o   (miss_cnt_o),
    .edit_en_i    (edit_en_i),
    .edit_field_i (edit_field_i),
    .field_blank_o(field_blank_o)
  );

  // Register file responder: data one cycle after the strobe, filler otherwise
  always @(posedge clk) begin
    if (rd_en_o) rd_data_i <= rf[rd_addr_o];
    else         rd_data_i <= 8'hEE;
  end

  // Event monitor sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (loaded_o) begin
      load_cnt++;
      load_cyc = cyc;
    end
    if (bus_gnt_i && !gnt_prev) gnt_cyc = cyc;
    gnt_prev = bus_gnt_i;
    if (bus_req_o) req_cnt++;
    if (rd_en_o) rd_cnt++;
    if (shadow_o !== shadow_prev) begin
      chg_cnt++;
      if (!loaded_o) bad_chg++;
    end
    shadow_prev = shadow_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int gap);
    vsync = 1'b0;
    cycles(2);
    vsync = 1'b1;
    cycles(gap);
  endtask

  task automatic pulse_dirty();
    dirty_i = 1'b1;
    cycles(1);
    dirty_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; vsync = 1'b1; dirty_i = 1'b0;
    gnt_auto = 1'b1; gnt_man = 1'b0; gnt_kill = 1'b0;
    edit_en_i = 1'b0; edit_field_i = 4'd0;
    for (int i = 0; i < 256; i++) rf[i] = 8'hEE;
    cycles(3);
    total++; if (bus_req_o !== 1'b0) $display("FAIL reset_bus_req got=%b exp=0", bus_req_o); else passed++;
    total++; if (rd_en_o !== 1'b0) $display("FAIL reset_rd_en got=%b exp=0", rd_en_o); else passed++;
    total++; if (rd_addr_o !== 8'h00) $display("FAIL reset_rd_addr got=%h exp=00", rd_addr_o); else passed++;
    total++; if (shadow_o !== 72'h0) $display("FAIL reset_shadow got=%h exp=0", shadow_o); else passed++;
    total++; if (loaded_o !== 1'b0) $display("FAIL reset_loaded got=%b exp=0", loaded_o); else passed++;
    total++; if (miss_cnt_o !== 8'h00) $display("FAIL reset_miss got=%0d exp=0", miss_cnt_o); else passed++;
    total++; if (field_blank_o !== 9'h000) $display("FAIL reset_blank got=%h exp=000", field_blank_o); else passed++;
    reset = 1'b0;
    cycles(5);
    total++; if (bus_req_o !== 1'b0) $display("FAIL idle_no_retrace_req got=%b exp=0", bus_req_o); else passed++;
  endtask

  task automatic test_first_load();
    int l0, r0, d0, b0;
    for (int i = 0; i < 9; i++) rf[i] = 8'(8'h11 * (i + 1));
    l0 = load_cnt; r0 = req_cnt; d0 = rd_cnt; b0 = bad_chg;
    frame(30);
    total++; if (shadow_o !== 72'h998877665544332211) $display("FAIL first_shadow got=%h exp=998877665544332211", shadow_o); else passed++;
    total++; if (load_cnt - l0 !== 1) $display("FAIL first_load_pulses got=%0d exp=1", load_cnt - l0); else passed++;
    total++; if (load_cyc - gnt_cyc !== 11) $display("FAIL first_latency got=%0d exp=11", load_cyc - gnt_cyc); else passed++;
    total++; if (req_cnt - r0 !== 11) $display("FAIL first_req_cycles got=%0d exp=11", req_cnt - r0); else passed++;
    total++; if (rd_cnt - d0 !== 9) $display("FAIL first_reads got=%0d exp=9", rd_cnt - d0); else passed++;
    total++; if (bad_chg - b0 !== 0) $display("FAIL first_tear got=%0d exp=0", bad_chg - b0); else passed++;
  endtask

  task automatic test_no_dirty();
    int l0, r0;
    l0 = load_cnt; r0 = req_cnt;
    repeat (3) frame(30);
    total++; if (req_cnt - r0 !== 0) $display("FAIL nodirty_req got=%0d exp=0", req_cnt - r0); else passed++;
    total++; if (load_cnt - l0 !== 0) $display("FAIL nodirty_load got=%0d exp=0", load_cnt - l0); else passed++;
    rf[0] = 8'hA0;
    pulse_dirty();
    l0 = load_cnt;
    frame(30);
    frame(30);
    total++; if (load_cnt - l0 !== 1) $display("FAIL dirty_one_load got=%0d exp=1", load_cnt - l0); else passed++;
    total++; if (shadow_o !== 72'h9988776655443322A0) $display("FAIL dirty_shadow got=%h exp=9988776655443322a0", shadow_o); else passed++;
  endtask

  task automatic test_timeout();
    int l0, r0;
    gnt_auto = 1'b0; gnt_man = 1'b0;
    pulse_dirty();
    l0 = load_cnt; r0 = req_cnt;
    frame(80);
    total++; if (req_cnt - r0 !== 64) $display("FAIL tmo_req_cycles got=%0d exp=64", req_cnt - r0); else passed++;
    total++; if (miss_cnt_o !== 8'd1) $display("FAIL tmo_miss got=%0d exp=1", miss_cnt_o); else passed++;
    total++; if (load_cnt - l0 !== 0) $display("FAIL tmo_no_load got=%0d exp=0", load_cnt - l0); else passed++;
    gnt_auto = 1'b1;
    l0 = load_cnt;
    frame(30);
    total++; if (load_cnt - l0 !== 1) $display("FAIL tmo_pending_load got=%0d exp=1", load_cnt - l0); else passed++;
    gnt_auto = 1'b0;
    pulse_dirty();
    repeat (300) frame(70);
    total++; if (miss_cnt_o !== 8'd255) $display("FAIL tmo_saturate got=%0d exp=255", miss_cnt_o); else passed++;
    total++; if (bus_req_o !== 1'b0) $display("FAIL tmo_req_dropped got=%b exp=0", bus_req_o); else passed++;
    gnt_auto = 1'b1;
    frame(30);
  endtask

  task automatic test_abort();
    int l0, d0, n;
    for (int i = 0; i < 9; i++) rf[i] = 8'(8'hC0 + i);
    pulse_dirty();
    l0 = load_cnt; d0 = rd_cnt; n = 0;
    vsync = 1'b0;
    cycles(2);
    vsync = 1'b1;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (rd_en_o) n++;
    end
    gnt_kill = 1'b1;
    total++; if (n !== 4) $display("FAIL abort_wait_reads got=%0d exp=4", n); else passed++;
    cycles(3);
    gnt_kill = 1'b0;
    cycles(30);
    total++; if (load_cnt - l0 !== 0) $display("FAIL abort_no_load got=%0d exp=0", load_cnt - l0); else passed++;
    total++; if (shadow_o !== 72'h9988776655443322A0) $display("FAIL abort_shadow got=%h exp=9988776655443322a0", shadow_o); else passed++;
    total++; if (rd_cnt - d0 !== 4) $display("FAIL abort_reads got=%0d exp=4", rd_cnt - d0); else passed++;
    l0 = load_cnt;
    frame(30);
    total++; if (load_cnt - l0 !== 1) $display("FAIL abort_reload got=%0d exp=1", load_cnt - l0); else passed++;
    total++; if (shadow_o !== 72'hC8C7C6C5C4C3C2C1C0) $display("FAIL abort_reload_shadow got=%h exp=c8c7c6c5c4c3c2c1c0", shadow_o); else passed++;
  endtask

  task automatic test_mid_read_change();
    int l0, c0, b0, n;
    for (int i = 0; i < 9; i++) rf[i] = 8'(8'h01 + i);
    pulse_dirty();
    l0 = load_cnt; c0 = chg_cnt; b0 = bad_chg; n = 0;
    vsync = 1'b0;
    cycles(2);
    vsync = 1'b1;
    for (int k = 0; k < 60 && n < 3; k++) begin
      @(negedge clk);
      if (rd_en_o) n++;
    end
    for (int i = 0; i < 9; i++) rf[i] = 8'(8'hF0 + i);
    total++; if (n !== 3) $display("FAIL mid_wait_reads got=%0d exp=3", n); else passed++;
    cycles(30);
    total++; if (shadow_o !== 72'hF8F7F6F5F4F3F20201) $display("FAIL mid_shadow got=%h exp=f8f7f6f5f4f3f20201", shadow_o); else passed++;
    total++; if (load_cnt - l0 !== 1) $display("FAIL mid_load got=%0d exp=1", load_cnt - l0); else passed++;
    total++; if (chg_cnt - c0 !== 1) $display("FAIL mid_changes got=%0d exp=1", chg_cnt - c0); else passed++;
    total++; if (bad_chg - b0 !== 0) $display("FAIL mid_tear got=%0d exp=0", bad_chg - b0); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    pulse_dirty();
    vsync = 1'b0;
    cycles(2);
    vsync = 1'b1;
    for (int k = 0; k < 60 && n < 2; k++) begin
      @(negedge clk);
      if (rd_en_o) n++;
    end
    total++; if (n !== 2) $display("FAIL rstmid_wait_reads got=%0d exp=2", n); else passed++;
    reset = 1'b1;
    cycles(1);
    total++; if (bus_req_o !== 1'b0) $display("FAIL rstmid_req got=%b exp=0", bus_req_o); else passed++;
    total++; if (rd_en_o !== 1'b0) $display("FAIL rstmid_rd_en got=%b exp=0", rd_en_o); else passed++;
    total++; if (shadow_o !== 72'h0) $display("FAIL rstmid_shadow got=%h exp=0", shadow_o); else passed++;
    reset = 1'b0;
    cycles(5);
  endtask

  task automatic test_blink();
    logic [8:0] exp;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    edit_en_i = 1'b1;
    edit_field_i = 4'd4;
    for (int f = 1; f <= 34; f++) begin
      frame(20);
`ifdef VGA_FIELD_BLINK_EN
      exp = (((f / 16) % 2) == 1) ? 9'h010 : 9'h000;
`else
      exp = 9'h000;
`endif
      total++; if (field_blank_o !== exp) $display("FAIL blink_frame%0d got=%h exp=%h", f, field_blank_o, exp); else passed++;
      if (f == 20) begin
        edit_field_i = 4'd9;
        cycles(3);
        total++; if (field_blank_o !== 9'h000) $display("FAIL blink_field9 got=%h exp=000", field_blank_o); else passed++;
        edit_field_i = 4'd4;
        edit_en_i = 1'b0;
        cycles(3);
        total++; if (field_blank_o !== 9'h000) $display("FAIL blink_edit_off got=%h exp=000", field_blank_o); else passed++;
        edit_en_i = 1'b1;
        cycles(3);
        total++; if (field_blank_o !== exp) $display("FAIL blink_edit_back got=%h exp=%h", field_blank_o, exp); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_no_dirty();
    test_timeout();
    test_abort();
    test_mid_read_change();
    test_reset_mid();
    test_blink();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
